// File: rtl/mem_port_arbiter.sv
// Two-source (imem/dmem) arbiter onto one in-order memory port, with a tag FIFO for response steering.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is fixed priority (DMEM over IMEM).
module mem_port_arbiter #(
    parameter int DATA_W          = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              imem_req_vld,
    output logic              imem_req_rdy,
    input  logic [DATA_W-1:0] imem_req,
    output logic              imem_rsp_vld,
    input  logic              imem_rsp_rdy,
    output logic [DATA_W-1:0] imem_rsp,
    input  logic              dmem_req_vld,
    output logic              dmem_req_rdy,
    input  logic [DATA_W-1:0] dmem_req,
    output logic              dmem_rsp_vld,
    input  logic              dmem_rsp_rdy,
    output logic [DATA_W-1:0] dmem_rsp,
    output logic              mem_req_vld,
    input  logic              mem_req_rdy,
    output logic [DATA_W-1:0] mem_req,
    input  logic              mem_rsp_vld,
    output logic              mem_rsp_rdy,
    input  logic [DATA_W-1:0] mem_rsp
);

    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(MAX_OUTSTANDING);
    localparam logic IDLE   = 1'b0;
    localparam logic LOCKED = 1'b1;

    logic [PTR_W:0]   count;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             tag_mem [MAX_OUTSTANDING];
    logic             lock_st;
    logic             lock_src;
    logic             grant_dmem;
    logic             grant_vld;
    logic             not_full;
    logic             not_empty;
    logic             head_dmem;
    logic             push;
    logic             pop;

`ifdef MEM_ARB_RR_EN
    logic last_grant;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= 1'b0;
        end else if (push) begin
            last_grant <= grant_dmem;
        end
    end
`endif

    // A stalled request keeps its grant so the forwarded packet cannot change under the memory.
    always_comb begin
        grant_dmem = 1'b0;
        if (lock_st == LOCKED) begin
            grant_dmem = lock_src;
        end else if (imem_req_vld && dmem_req_vld) begin
`ifdef MEM_ARB_RR_EN
            grant_dmem = !last_grant;
`else
            grant_dmem = 1'b1;
`endif
        end else begin
            grant_dmem = dmem_req_vld;
        end
    end

    assign grant_vld = grant_dmem ? dmem_req_vld : imem_req_vld;
    assign not_full  = (count != FULL_CNT);
    assign not_empty = (count != '0);
    assign head_dmem = tag_mem[rd_ptr];

    assign mem_req_vld  = !rst && grant_vld && not_full;
    assign mem_req      = grant_dmem ? dmem_req : imem_req;
    assign imem_req_rdy = mem_req_vld && !grant_dmem && mem_req_rdy;
    assign dmem_req_rdy = mem_req_vld && grant_dmem && mem_req_rdy;
    assign push         = mem_req_vld && mem_req_rdy;

    // With no tag outstanding a response has no owner, so it is held off rather than routed.
    assign imem_rsp_vld = !rst && not_empty && !head_dmem && mem_rsp_vld;
    assign dmem_rsp_vld = !rst && not_empty && head_dmem && mem_rsp_vld;
    assign mem_rsp_rdy  = !rst && not_empty && (head_dmem ? dmem_rsp_rdy : imem_rsp_rdy);
    assign imem_rsp     = mem_rsp;
    assign dmem_rsp     = mem_rsp;
    assign pop          = mem_rsp_vld && mem_rsp_rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_st  <= IDLE;
            lock_src <= 1'b0;
        end else if (lock_st == IDLE) begin
            if (mem_req_vld && !mem_req_rdy) begin
                lock_st  <= LOCKED;
                lock_src <= grant_dmem;
            end
        end else if (push) begin
            lock_st <= IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) tag_mem[wr_ptr] <= grant_dmem;
    end

endmodule
